// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl: single-clock sequencer for the wave-generator datapath.
// Produces a divided sample strobe, holds the datapath in reset while
// stopped, double-buffers host configuration (applied on a strobe) and
// ramps the amplitude in fixed steps so starts/stops/changes do not click.
module wave_seq_ctrl #(
  parameter int DIV_W     = 16,
  parameter int AMP_W     = 12,
  parameter int PH_W      = 16,
  parameter int RAMP_STEP = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [AMP_W-1:0] cfg_amp,
  input  logic [PH_W-1:0]  cfg_phaseoffset,
  input  logic [PH_W-1:0]  cfg_phaseadd,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_commit,
  output logic             sample_en,
  output logic             dp_reset,
  output logic [AMP_W-1:0] amp_out,
  output logic [PH_W-1:0]  phaseoffset_out,
  output logic [PH_W-1:0]  phaseadd_out,
  output logic             pending,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10
  } state_t;

  // One extra bit so amp +/- step never wraps before clamping.
  localparam int EW = AMP_W + 1;

  state_t           st;
  logic             commit_q;
  logic             commit_edge;

  logic [AMP_W-1:0] sh_amp;
  logic [PH_W-1:0]  sh_po;
  logic [PH_W-1:0]  sh_pa;
  logic [DIV_W-1:0] sh_div;

  logic [AMP_W-1:0] amp_target;
  logic [DIV_W-1:0] div_active;
  logic [DIV_W-1:0] cnt;

  logic [EW-1:0]    amp_x;
  logic [EW-1:0]    eff_x;
  logic [EW-1:0]    step_x;
  logic [EW-1:0]    up_x;
  logic [EW-1:0]    dn_x;
  logic [EW-1:0]    amp_ramped_x;

  assign state       = st;
  assign commit_edge = cfg_commit & ~commit_q;

  // Strobe is a pure decode of registered state: the divider has wrapped
  // while the sequencer is active. IDLE pins cnt at 0, so gate on state.
  assign sample_en = (st != S_IDLE) && (cnt == '0);

  // Host commit edge detect and shadow capture (active in every state).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_q <= 1'b0;
      sh_amp   <= '0;
      sh_po    <= '0;
      sh_pa    <= '0;
      sh_div   <= '0;
    end else begin
      commit_q <= cfg_commit;
      if (commit_edge) begin
        sh_amp <= cfg_amp;
        sh_po  <= cfg_phaseoffset;
        sh_pa  <= cfg_phaseadd;
        sh_div <= cfg_div;
      end
    end
  end

  // Next ramped amplitude: one clamped step toward the effective target.
  // STOP ramps toward zero; the target used is the pre-apply value.
  always_comb begin
    eff_x        = (st == S_STOP) ? '0 : {1'b0, amp_target};
    amp_x        = {1'b0, amp_out};
    step_x       = EW'(RAMP_STEP);
    up_x         = amp_x + step_x;
    dn_x         = amp_x - step_x;
    amp_ramped_x = amp_x;
    if (amp_x < eff_x)
      amp_ramped_x = (up_x > eff_x) ? eff_x : up_x;
    else if (amp_x > eff_x)
      amp_ramped_x = ((amp_x - eff_x) > step_x) ? dn_x : eff_x;
  end

  // Sequencer FSM: divider, apply of shadowed config, ramp and run/stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st              <= S_IDLE;
      dp_reset        <= 1'b1;
      amp_out         <= '0;
      phaseoffset_out <= '0;
      phaseadd_out    <= '0;
      amp_target      <= '0;
      div_active      <= '0;
      cnt             <= '0;
      pending         <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          cnt     <= '0;
          amp_out <= '0;
          if (enable) begin
            // Start from whatever the shadow holds; a commit landing in
            // this same cycle stays pending for the first strobe.
            phaseoffset_out <= sh_po;
            phaseadd_out    <= sh_pa;
            amp_target      <= sh_amp;
            div_active      <= sh_div;
            cnt             <= sh_div;
            pending         <= commit_edge;
            dp_reset        <= 1'b0;
            st              <= S_RUN;
          end else begin
            pending <= pending | commit_edge;
          end
        end

        default: begin
          if (sample_en) begin
            amp_out <= amp_ramped_x[AMP_W-1:0];
            if (pending) begin
              phaseoffset_out <= sh_po;
              phaseadd_out    <= sh_pa;
              amp_target      <= sh_amp;
              div_active      <= sh_div;
              cnt             <= sh_div;
            end else begin
              cnt <= div_active;
            end
            // An edge in the strobe cycle wrote a newer shadow that was
            // not the one applied, so it remains pending.
            pending <= commit_edge;
          end else begin
            cnt     <= cnt - DIV_W'(1);
            pending <= pending | commit_edge;
          end

          if (st == S_RUN) begin
            if (!enable)
              st <= S_STOP;
          end else if (enable) begin
            st <= S_RUN;
          end else if (sample_en && (amp_ramped_x == '0)) begin
            st       <= S_IDLE;
            dp_reset <= 1'b1;
            cnt      <= '0;
          end
        end
      endcase
    end
  end

endmodule
